// File: rtl/processinho_sequencer.sv
// processinho_sequencer: operator front end for the processinho datapath.
// Two pushbuttons (advance / abort) are synchronized, debounced and turned
// into single-cycle events that walk an FSM through operand A, operand B,
// opcode entry, a fixed-length execute window and a result display state.
module processinho_sequencer #(
    parameter int DEB_CYCLES  = 16,
    parameter int EXEC_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_next,
    input  logic       key_cancel,
    input  logic [3:0] switches,
    output logic [3:0] operando,
    output logic       setRegA,
    output logic       setRegB,
    output logic [3:0] ula_operation,
    output logic       latch_ula,
    output logic       busy,
    output logic       done,
    output logic [2:0] step
);

    // Counter widths: the debounce counter only needs to reach DEB_CYCLES-1
    // and the execute counter only EXEC_CYCLES-1.
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Key index 0 is "advance", index 1 is "abort".
    logic [1:0]         key_raw;
    logic [1:0]         sync1_q;
    logic [1:0]         sync2_q;
    logic [1:0]         filt_q;
    logic [1:0]         filt_d;
    logic [1:0]         filt_prev_q;
    logic [1:0][DW-1:0] deb_cnt_q;
    logic [1:0][DW-1:0] deb_cnt_d;
    logic [1:0]         key_ev;
    logic               ev_next;
    logic               ev_cancel;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         operando_q;
    logic [3:0]         operando_d;
    logic [3:0]         ula_q;
    logic [3:0]         ula_d;
    logic               set_a_q;
    logic               set_a_d;
    logic               set_b_q;
    logic               set_b_d;
    logic [EW-1:0]      exec_cnt_q;
    logic [EW-1:0]      exec_cnt_d;

    assign key_raw = {key_cancel, key_next};

    // Debounce: the filtered level follows the synchronized key only after
    // DEB_CYCLES consecutive disagreeing samples; any agreeing sample restarts.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != filt_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    filt_d[k]    = sync2_q[k];
                    deb_cnt_d[k] = '0;
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Synchronizer chain, debounce state and edge-detect history per key.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            deb_cnt_q   <= '0;
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    // A rising filtered level yields exactly one event cycle per press.
    assign key_ev    = filt_q & ~filt_prev_q;
    assign ev_next   = key_ev[0];
    assign ev_cancel = key_ev[1];

    // Next-state and datapath-strobe decode; abort outranks advance.
    always_comb begin
        state_d    = state_q;
        operando_d = operando_q;
        ula_d      = ula_q;
        set_a_d    = 1'b0;
        set_b_d    = 1'b0;
        exec_cnt_d = exec_cnt_q;
        if (ev_cancel) begin
            state_d    = S_A;
            exec_cnt_d = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (ev_next) begin
                        operando_d = switches;
                        set_a_d    = 1'b1;
                        state_d    = S_B;
                    end
                end
                S_B: begin
                    if (ev_next) begin
                        operando_d = switches;
                        set_b_d    = 1'b1;
                        state_d    = S_OP;
                    end
                end
                S_OP: begin
                    if (ev_next) begin
                        ula_d      = switches;
                        exec_cnt_d = '0;
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Advance presses are deliberately ignored while executing.
                    if (exec_cnt_q == EXEC_LAST) begin
                        exec_cnt_d = '0;
                        state_d    = S_SHOW;
                    end else begin
                        exec_cnt_d = exec_cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (ev_next) begin
                        state_d = S_A;
                    end
                end
                default: begin
                    state_d    = S_A;
                    exec_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM state, operand/opcode holding registers and load strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_A;
            operando_q <= '0;
            ula_q      <= '0;
            set_a_q    <= 1'b0;
            set_b_q    <= 1'b0;
            exec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            operando_q <= operando_d;
            ula_q      <= ula_d;
            set_a_q    <= set_a_d;
            set_b_q    <= set_b_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    // Status outputs decode straight from the state register, so the execute
    // strobe spans exactly the cycles spent in S_EXEC and drops with any exit.
    assign operando      = operando_q;
    assign ula_operation = ula_q;
    assign setRegA       = set_a_q;
    assign setRegB       = set_b_q;
    assign latch_ula     = (state_q == S_EXEC);
    assign busy          = (state_q == S_EXEC);
    assign done          = (state_q == S_SHOW);
    assign step          = state_q;

endmodule

// File: tb/tb_processinho_sequencer.sv
// Directed bench for processinho_sequencer. Instance A uses DEB_CYCLES=4,
// EXEC_CYCLES=2; instance B uses DEB_CYCLES=1, EXEC_CYCLES=8 with its own keys.
module tb_processinho_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_next_a, key_cancel_a, key_next_b, key_cancel_b;
    logic [3:0] switches;

    logic [3:0] operando_a, ula_operation_a, operando_b, ula_operation_b;
    logic       setRegA_a, setRegB_a, latch_ula_a, busy_a, done_a;
    logic       setRegA_b, setRegB_b, latch_ula_b, busy_b, done_b;
    logic [2:0] step_a, step_b;

    int total = 0;
    int bad   = 0;
    int n_seta = 0, n_setb = 0, n_latch_a = 0, n_latch_b = 0, n_excl = 0;

    always #5 clock = ~clock;

    processinho_sequencer #(.DEB_CYCLES(4), .EXEC_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .key_next(key_next_a), .key_cancel(key_cancel_a),
        .switches(switches), .operando(operando_a), .setRegA(setRegA_a), .setRegB(setRegB_a),
        .ula_operation(ula_operation_a), .latch_ula(latch_ula_a), .busy(busy_a),
        .done(done_a), .step(step_a)
    );

    processinho_sequencer #(.DEB_CYCLES(1), .EXEC_CYCLES(8)) dut_b (
        .clock(clock), .reset(reset), .key_next(key_next_b), .key_cancel(key_cancel_b),
        .switches(switches), .operando(operando_b), .setRegA(setRegA_b), .setRegB(setRegB_b),
        .ula_operation(ula_operation_b), .latch_ula(latch_ula_b), .busy(busy_b),
        .done(done_b), .step(step_b)
    );

    // Mid-cycle pulse counters and strobe-overlap detector.
    always @(negedge clock) begin
        if (setRegA_a === 1'b1)   n_seta    <= n_seta + 1;
        if (setRegB_a === 1'b1)   n_setb    <= n_setb + 1;
        if (latch_ula_a === 1'b1) n_latch_a <= n_latch_a + 1;
        if (latch_ula_b === 1'b1) n_latch_b <= n_latch_b + 1;
        if ($countones({setRegA_a, setRegB_a, latch_ula_a}) > 1 ||
            $countones({setRegA_b, setRegB_b, latch_ula_b}) > 1)
            n_excl <= n_excl + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instance A: a held press becomes visible 7 ticks after the key rises.
    task automatic press_a(input logic [3:0] sw);
        switches   = sw;
        key_next_a = 1'b1;
        repeat (7) tick();
    endtask

    task automatic release_a();
        key_next_a   = 1'b0;
        key_cancel_a = 1'b0;
        repeat (7) tick();
    endtask

    // Instance B: the same with a one-sample debounce, 4 ticks.
    task automatic press_b(input logic [3:0] sw);
        switches   = sw;
        key_next_b = 1'b1;
        repeat (4) tick();
    endtask

    task automatic release_b();
        key_next_b   = 1'b0;
        key_cancel_b = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int early;
        int first;
        int base;

        // Reset with both keys of A held.
        reset        = 1'b0;
        key_next_a   = 1'b1;
        key_cancel_a = 1'b1;
        key_next_b   = 1'b0;
        key_cancel_b = 1'b0;
        switches     = 4'd5;
        repeat (3) tick();
        chk("rst_step_a", step_a, 0);
        chk("rst_outs_a", {operando_a, ula_operation_a, setRegA_a, setRegB_a, latch_ula_a, busy_a, done_a}, 0);
        chk("rst_outs_b", {step_b, operando_b, ula_operation_b, setRegA_b, setRegB_b, latch_ula_b, busy_b, done_b}, 0);

        // Release with next still held: one event after debounce latency.
        key_cancel_a = 1'b0;
        reset        = 1'b1;
        base  = n_seta;
        early = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (setRegA_a !== 1'b0 || step_a !== 3'd0) early++;
        end
        chk("rst_no_early_evt", early, 0);
        tick();
        chk("rst_seta", setRegA_a, 1);
        chk("rst_operando", operando_a, 5);
        chk("rst_step1", step_a, 1);
        repeat (20) tick();
        chk("hold_single_evt", n_seta - base, 1);
        chk("hold_step", step_a, 1);
        release_a();

        // Full sequence: B operand then opcode then execute.
        base = n_setb;
        press_a(4'd3);
        chk("setb_strobe", setRegB_a, 1);
        chk("setb_operando", operando_a, 3);
        chk("setb_step", step_a, 2);
        chk("setb_no_seta", setRegA_a, 0);
        release_a();
        chk("setb_one_cycle", n_setb - base, 1);

        base = n_latch_a;
        press_a(4'd1);
        chk("exec_step", step_a, 3);
        chk("exec_latch0", latch_ula_a, 1);
        chk("exec_busy", busy_a, 1);
        chk("exec_ula", ula_operation_a, 1);
        tick();
        chk("exec_latch1", latch_ula_a, 1);
        tick();
        chk("show_step", step_a, 4);
        chk("show_done", done_a, 1);
        chk("show_latch", latch_ula_a, 0);
        chk("show_busy", busy_a, 0);
        release_a();
        chk("latch_cycles_a", n_latch_a - base, 2);
        chk("show_holds", step_a, 4);

        press_a(4'hE);
        chk("show_to_a", step_a, 0);
        chk("show_keep_opnd", operando_a, 3);
        chk("show_keep_ula", ula_operation_a, 1);
        release_a();

        // Bounce: 3 high / 1 low never satisfies a 4-sample debounce.
        switches = 4'hA;
        base = n_seta;
        for (int r = 0; r < 10; r++) begin
            key_next_a = 1'b1;
            repeat (3) tick();
            key_next_a = 1'b0;
            tick();
        end
        chk("bounce_step", step_a, 0);
        chk("bounce_no_evt", n_seta - base, 0);
        key_next_a = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (setRegA_a === 1'b1 && first == 0) first = i;
        end
        chk("bounce_latency", first, 7);
        chk("bounce_one_pulse", n_seta - base, 1);
        chk("bounce_operando", operando_a, 4'hA);
        release_a();
        chk("bounce_step1", step_a, 1);

        // Cancel together with next in S_B: cancel wins.
        base = n_setb;
        key_next_a   = 1'b1;
        key_cancel_a = 1'b1;
        repeat (7) tick();
        chk("cancel_sb_step", step_a, 0);
        release_a();
        chk("cancel_sb_no_setb", n_setb - base, 0);
        chk("cancel_sb_stays", step_a, 0);

        // Cancel in S_OP keeps operand and opcode.
        press_a(4'd5);
        release_a();
        press_a(4'd6);
        release_a();
        chk("cancel_op_pre", step_a, 2);
        base = n_latch_a;
        key_cancel_a = 1'b1;
        repeat (7) tick();
        chk("cancel_op_step", step_a, 0);
        chk("cancel_op_ula", ula_operation_a, 1);
        chk("cancel_op_opnd", operando_a, 6);
        release_a();
        chk("cancel_op_no_latch", n_latch_a - base, 0);

        // Instance B: 8-cycle execute window with an ignored advance.
        press_b(4'd2);
        release_b();
        press_b(4'd4);
        release_b();
        chk("b_pre_op", step_b, 2);
        base = n_latch_b;
        press_b(4'd9);
        chk("b_exec_step", step_b, 3);
        chk("b_exec_latch", latch_ula_b, 1);
        chk("b_exec_ula", ula_operation_b, 9);
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) key_next_b = 1'b0;
            if (i == 4) key_next_b = 1'b1;
            if (i == 8) key_next_b = 1'b0;
            tick();
            if (i == 7) begin
                chk("b_next_ignored_step", step_b, 3);
                chk("b_next_ignored_latch", latch_ula_b, 1);
            end
        end
        chk("b_show_step", step_b, 4);
        chk("b_show_done", done_b, 1);
        chk("b_show_latch", latch_ula_b, 0);
        chk("b_show_busy", busy_b, 0);
        repeat (3) tick();
        chk("b_latch_cycles", n_latch_b - base, 8);
        press_b(4'd0);
        chk("b_show_to_a", step_b, 0);
        release_b();

        // Instance B: cancel in S_EXEC drops latch one edge after the event.
        press_b(4'd2);
        release_b();
        press_b(4'd4);
        release_b();
        press_b(4'd7);
        chk("b_exec2_step", step_b, 3);
        key_next_b   = 1'b0;
        key_cancel_b = 1'b1;
        repeat (3) tick();
        chk("b_cancel_pre_latch", latch_ula_b, 1);
        tick();
        chk("b_cancel_latch", latch_ula_b, 0);
        chk("b_cancel_step", step_b, 0);
        chk("b_cancel_ula", ula_operation_b, 7);
        release_b();

        // Instance B: reset in the second execute cycle.
        press_b(4'd2);
        release_b();
        press_b(4'd4);
        release_b();
        press_b(4'hC);
        chk("b_exec3_step", step_b, 3);
        key_next_b = 1'b0;
        tick();
        chk("b_exec3_latch", latch_ula_b, 1);
        reset = 1'b0;
        tick();
        chk("b_rst_latch", latch_ula_b, 0);
        chk("b_rst_ula", ula_operation_b, 0);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_step", step_b, 0);
        chk("a_rst_ula", ula_operation_a, 0);
        reset = 1'b1;
        tick();

        chk("strobe_exclusive", n_excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processinho_sequencer.md
# processinho_sequencer

Control FSM for the processinho datapath. It turns two pushbuttons and a 4-bit switch bank into the datapath control strobes. The operator loads operand A, then operand B, then the opcode, and the block pulses the register loads and holds `latch_ula` for a fixed execute window. It sits between the board I/O and processinho and drives that block's `setRegA`, `setRegB`, `operando`, `ula_operation` and `latch_ula` inputs.

## Interface
Parameters:
- `DEB_CYCLES`, default 16: consecutive stable samples required to accept a key level change (min 1).
- `EXEC_CYCLES`, default 2: cycles `latch_ula` is held high per execution (min 1).

Ports:
- `clock`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low; sampled only on `clock` rising edge.
- `key_next`  in  1  asynchronous, active-high "advance" button.
- `key_cancel`  in  1  asynchronous, active-high "abort" button.
- `switches`  in  4  operand/opcode source.
- `operando`  out  4  registered operand driven to regA/regB.
- `setRegA`  out  1  one-cycle load strobe for regA.
- `setRegB`  out  1  one-cycle load strobe for regB.
- `ula_operation`  out  4  registered opcode, held between executions.
- `latch_ula`  out  1  execute strobe, high for `EXEC_CYCLES` cycles.
- `busy`  out  1  high while in EXEC.
- `done`  out  1  high while in SHOW.
- `step`  out  3  current state code, for LEDs.

## Operation
- **Key conditioning.** Each key goes through a 2-flop synchronizer, then a debounce filter, then a rising-edge detector.
  - The filtered level flips only after `DEB_CYCLES` consecutive synchronized samples that differ from it.
  - Any agreeing sample clears the counter.
  - A rising edge of the filtered level gives a one-cycle event: `ev_next` or `ev_cancel`.
- **States.** `step` codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Codes 5–7 are unused and return to S_A on the next edge.
- **Transitions.**
  - S_A, on `ev_next`: `operando<=switches`, `setRegA<=1` for one cycle, go to S_B.
  - S_B, on `ev_next`: `operando<=switches`, `setRegB<=1` for one cycle, go to S_OP.
  - S_OP, on `ev_next`: `ula_operation<=switches`, go to S_EXEC.
  - S_EXEC: `latch_ula=1` and `busy=1` for exactly `EXEC_CYCLES` cycles, then go to S_SHOW. `ev_next` is ignored.
  - S_SHOW: `done=1`. On `ev_next`, go to S_A. `operando` and `ula_operation` are retained.
- **Cancel.**
  - `ev_cancel` in any state sends the FSM to S_A on the next edge and clears `latch_ula`, `setRegA` and `setRegB`.
  - `operando` and `ula_operation` are left unchanged.
  - Cancel has priority over a simultaneous `ev_next`.
- **Strobe alignment.** `operando` updates on the same edge that raises `setRegA` or `setRegB`, so the data is stable when the register samples it.
- **Mutual exclusion.** `setRegA`, `setRegB` and `latch_ula` are never high in the same cycle.

## Timing
- **Reset (`reset=0` at an edge).**
  - State goes to S_A; every output goes to 0, including `operando`, `ula_operation` and `step`.
  - Synchronizers, debounce counters and filtered levels are cleared.
  - A key still held when reset releases produces one event after the normal debounce latency.
- **Key latency.** Let edge 0 be the first edge that captures key=1 in sync stage 1.
  - The filtered level rises after edge `DEB_CYCLES+1`.
  - The FSM acts on edge `DEB_CYCLES+2`.
  - The resulting strobe is high in the cycle after edge `DEB_CYCLES+2`.
  - A key holding high indefinitely yields exactly one event. A release must also pass debounce before a new press counts.
- **Execute window.** Entering S_EXEC on edge E gives `latch_ula=1` in the cycles after edges E … E+`EXEC_CYCLES`−1. After edge E+`EXEC_CYCLES`: `latch_ula=0`, `busy=0`, `done=1`, `step=4`.
- **Mid-operation reset or cancel.** Either one in S_EXEC drops `latch_ula` after the next edge. The partial execution is not completed.

## Test plan
- **Reset.** `DEB_CYCLES=4`, `EXEC_CYCLES=2`. Hold `reset=0` for 3 cycles with both keys high → all outputs 0, `step=0`. After release → one S_A→S_B event at the specified latency, with `operando` equal to `switches`.
- **Full sequence.** Switches 5, press next; switches 3, press next; switches 1, press next.
  - `setRegA` high for exactly 1 cycle with `operando=5`.
  - `setRegB` high for 1 cycle with `operando=3`.
  - `ula_operation=1`, `latch_ula` high for exactly 2 cycles, then `done=1`, `step=4`.
- **Bounce.** Drive `key_next` high for 3 cycles, low for 1, repeated 10 times → no event, `step` stays 0. Then hold high 20 cycles → exactly one `setRegA` pulse, first strobe at edge 6.
- **Cancel.**
  - In S_OP, cancel → `step=0`, no `latch_ula`, `ula_operation` unchanged.
  - In S_B, raise next and cancel together → `step=0`, no `setRegB` pulse.
- **Execute window.** `EXEC_CYCLES=8`.
  - A next event during S_EXEC is ignored; S_SHOW is reached on time.
  - A second run with cancel in S_EXEC → `latch_ula=0` and `step=0` one edge after the event.
- **Reset mid-execute.** `reset=0` in the 2nd S_EXEC cycle → `latch_ula=0`, `ula_operation=0` and `busy=0` after that edge.
